// File: rtl/codec_ctrl_responder.sv
// codec_ctrl_responder - 3-wire control-port responder with codec-compatible register file
// Shifts 16-bit {addr,data} words in MSB-first on spi_sck and commits them on spi_csb rise.
module codec_ctrl_responder #(
  parameter int SYNC_STAGES = 2,
  parameter bit LR_BOTH_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       spi_csb,
  input  logic [6:0] rd_addr,
  output logic [8:0] rd_data,
  output logic       wr_strobe,
  output logic [6:0] wr_addr,
  output logic [8:0] wr_data,
  output logic       frame_err,
  output logic       addr_err,
  output logic       active,
  output logic [7:0] pd_bits,
  output logic [1:0] iwl,
  output logic [1:0] format,
  output logic [3:0] sr
);

  function automatic logic [8:0] def_val(input int idx);
    case (idx)
      0, 1:    def_val = 9'h097;
      2, 3:    def_val = 9'h079;
      4:       def_val = 9'h00A;
      5:       def_val = 9'h008;
      6:       def_val = 9'h09F;
      7:       def_val = 9'h00A;
      default: def_val = 9'h000;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, csb_sync;
  logic                   sck_d, csb_d;
  logic                   sck_rise, csb_rise, mosi_s;
  logic [15:0]            shreg, shreg_nx;
  logic [4:0]             bit_cnt, cnt_nx;
  logic [6:0]             w_addr;
  logic [8:0]             w_data;
  logic [8:0]             regs [0:9];

  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_sync[SYNC_STAGES-1] & ~sck_d;
  assign csb_rise = csb_sync[SYNC_STAGES-1] & ~csb_d;

  // A shift coinciding with a commit is folded in before decoding.
  assign shreg_nx = sck_rise ? {shreg[14:0], mosi_s} : shreg;
  assign cnt_nx   = (sck_rise && bit_cnt != 5'd31) ? bit_cnt + 5'd1 : bit_cnt;
  assign w_addr   = shreg_nx[15:9];
  assign w_data   = shreg_nx[8:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      csb_sync  <= '1;
      sck_d     <= 1'b0;
      csb_d     <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      csb_sync  <= {csb_sync[SYNC_STAGES-2:0], spi_csb};
      sck_d     <= sck_sync[SYNC_STAGES-1];
      csb_d     <= csb_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      addr_err  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      for (int i = 0; i < 10; i++) regs[i] <= def_val(i);
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      addr_err  <= 1'b0;
      if (csb_rise) begin
        shreg   <= '0;
        bit_cnt <= '0;
        if (cnt_nx >= 5'd16) begin
          wr_strobe <= 1'b1;
          wr_addr   <= w_addr;
          wr_data   <= w_data;
          if (w_addr == 7'h0F) begin
            for (int i = 0; i < 10; i++) regs[i] <= def_val(i);
          end else if (w_addr <= 7'h09) begin
            regs[w_addr[3:0]] <= w_data;
            // Left/right pairs R0/R1 and R2/R3 share a both-channels update bit.
            if (LR_BOTH_EN && w_data[8] && w_addr <= 7'h03) begin
              regs[{w_addr[3:1], 1'b0}] <= w_data;
              regs[{w_addr[3:1], 1'b1}] <= w_data;
            end
          end else begin
            addr_err <= 1'b1;
          end
        end else begin
          frame_err <= 1'b1;
        end
      end else begin
        shreg   <= shreg_nx;
        bit_cnt <= cnt_nx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active  <= 1'b0;
      pd_bits <= 8'h9F;
      iwl     <= 2'b10;
      format  <= 2'b10;
      sr      <= 4'h0;
    end else begin
      active  <= regs[9][0];
      pd_bits <= regs[6][7:0];
      iwl     <= regs[7][3:2];
      format  <= regs[7][1:0];
      sr      <= regs[8][5:2];
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_addr <= 7'h09) rd_data = regs[rd_addr[3:0]];
  end

endmodule

// File: tb/tb_codec_ctrl_responder.sv
// tb/tb_codec_ctrl_responder.sv - directed-vector bench for codec_ctrl_responder
module tb_codec_ctrl_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_sck = 1'b0, spi_mosi = 1'b0, spi_csb = 1'b1;
  logic [6:0] rd_addr = '0;

  logic [8:0] rd_data, wr_data, b_rd_data, b_wr_data;
  logic [6:0] wr_addr, b_wr_addr;
  logic       wr_strobe, frame_err, addr_err, active;
  logic       b_wr_strobe, b_frame_err, b_addr_err, b_active;
  logic [7:0] pd_bits, b_pd_bits;
  logic [1:0] iwl, format, b_iwl, b_format;
  logic [3:0] sr, b_sr;

  int n_checks = 0;
  int n_fail = 0;
  int n_wr, n_ferr, n_aerr;
  logic clr_cnt = 1'b0;
  logic [8:0] def_tab [16];

  always #5 clk = ~clk;

  codec_ctrl_responder #(.SYNC_STAGES(2), .LR_BOTH_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_csb(spi_csb),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_err(frame_err), .addr_err(addr_err), .active(active),
    .pd_bits(pd_bits), .iwl(iwl), .format(format), .sr(sr)
  );

  codec_ctrl_responder #(.SYNC_STAGES(2), .LR_BOTH_EN(1'b0)) dut_nolr (
    .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_csb(spi_csb),
    .rd_addr(rd_addr), .rd_data(b_rd_data), .wr_strobe(b_wr_strobe), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .frame_err(b_frame_err), .addr_err(b_addr_err), .active(b_active),
    .pd_bits(b_pd_bits), .iwl(b_iwl), .format(b_format), .sr(b_sr)
  );

  always @(posedge clk) begin
    if (clr_cnt) begin
      n_wr   <= 0;
      n_ferr <= 0;
      n_aerr <= 0;
    end else begin
      if (wr_strobe) n_wr   <= n_wr + 1;
      if (frame_err) n_ferr <= n_ferr + 1;
      if (addr_err)  n_aerr <= n_aerr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic read_a(input logic [6:0] a, output logic [8:0] va, output logic [8:0] vb);
    rd_addr = a;
    #1;
    va = rd_data;
    vb = b_rd_data;
  endtask

  task automatic send_frame(input logic [31:0] val, input int nbits);
    @(negedge clk) clr_cnt = 1'b1;
    @(negedge clk) clr_cnt = 1'b0;
    spi_csb = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_mosi = val[i];
      repeat (4) @(negedge clk);
      spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
    end
    repeat (4) @(negedge clk);
    spi_csb = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    logic [8:0] va, vb;
    def_tab = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A, 9'h008, 9'h09F, 9'h00A,
                9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    for (int a = 0; a < 16; a++) begin
      read_a(7'(a), va, vb);
      check($sformatf("rst_r%0d", a), va, def_tab[a]);
    end
    read_a(7'h40, va, vb);
    check("rst_unmapped", va, 9'h000);
    check("rst_active", active, 1'b0);
    check("rst_pd_bits", pd_bits, 8'h9F);
    check("rst_iwl", iwl, 2'b10);
    check("rst_format", format, 2'b10);
    check("rst_wr_strobe", wr_strobe, 1'b0);
    check("rst_wr_addr", wr_addr, 7'h00);

    send_frame(32'h0E5B, 16);
    read_a(7'h07, va, vb);
    check("r7_val", va, 9'h05B);
    check("r7_iwl", iwl, 2'b10);
    check("r7_format", format, 2'b11);
    check("r7_wr_cnt", n_wr, 1);
    check("r7_wr_addr", wr_addr, 7'h07);
    check("r7_wr_data", wr_data, 9'h05B);
    check("r7_ferr_cnt", n_ferr, 0);

    send_frame(32'h011F, 16);
    read_a(7'h00, va, vb);
    check("lr_r0", va, 9'h11F);
    check("nolr_r0", vb, 9'h11F);
    read_a(7'h01, va, vb);
    check("lr_r1", va, 9'h11F);
    check("nolr_r1", vb, 9'h097);

    send_frame(32'h1024, 16);
    check("r8_sr", sr, 4'h9);

    send_frame(32'h1201, 16);
    check("r9_active", active, 1'b1);
    check("r9_wr_cnt", n_wr, 1);
    send_frame(32'h1E00, 16);
    check("r15_active", active, 1'b0);
    check("r15_wr_cnt", n_wr, 1);
    check("r15_wr_addr", wr_addr, 7'h0F);
    check("r15_aerr_cnt", n_aerr, 0);
    read_a(7'h07, va, vb);
    check("r15_r7", va, 9'h00A);
    read_a(7'h00, va, vb);
    check("r15_r0", va, 9'h097);
    read_a(7'h08, va, vb);
    check("r15_r8", va, 9'h000);

    send_frame(32'h0ABC, 12);
    check("short_ferr_cnt", n_ferr, 1);
    check("short_wr_cnt", n_wr, 0);
    send_frame(32'h0A05, 16);
    check("after_short_wr_cnt", n_wr, 1);
    check("after_short_ferr_cnt", n_ferr, 0);
    read_a(7'h05, va, vb);
    check("after_short_r5", va, 9'h005);

    send_frame(32'hF0C00, 20);
    read_a(7'h06, va, vb);
    check("long_r6", va, 9'h000);
    check("long_pd_bits", pd_bits, 8'h00);
    check("long_wr_addr", wr_addr, 7'h06);

    send_frame(32'h1400, 16);
    check("bad_aerr_cnt", n_aerr, 1);
    check("bad_wr_cnt", n_wr, 1);
    check("bad_wr_addr", wr_addr, 7'h0A);
    read_a(7'h06, va, vb);
    check("bad_r6_kept", va, 9'h000);
    read_a(7'h0A, va, vb);
    check("bad_r10_read", va, 9'h000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
